// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the MIPS datapath (master) and the stall/flush
// sequencer (slave).
interface pipe_hazard_ctrl_if #(
  parameter int AW = 32
);
  logic [4:0]    id_rs;
  logic [4:0]    id_rt;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic          ex_memread;
  logic [4:0]    ex_rd;
  logic          mem_taken;
  logic [AW-1:0] mem_target;
  logic          icache_stall;
  logic          dcache_stall;

  logic          pc_en;
  logic          ifid_en;
  logic          idex_en;
  logic          exmem_en;
  logic          memwb_en;
  logic          ifid_flush;
  logic          idex_flush;
  logic          exmem_flush;
  logic          pc_redirect;
  logic [AW-1:0] redirect_pc;
  logic [31:0]   stall_cycles;
  logic [31:0]   flush_events;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rd,
           mem_taken, mem_target, icache_stall, dcache_stall,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, pc_redirect, redirect_pc,
           stall_cycles, flush_events
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rd,
           mem_taken, mem_target, icache_stall, dcache_stall,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, pc_redirect, redirect_pc,
           stall_cycles, flush_events
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline; defers redirects blocked by the I-cache.
// Optional performance counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int AW = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave i_hz
);

  typedef enum logic {RUN, PEND} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_pend_pc;
  logic [AW-1:0] w_pend_pc_next;

  logic          w_lu;
  logic          w_pc_en;
  logic          w_ifid_en;
  logic          w_idex_en;
  logic          w_exmem_en;
  logic          w_memwb_en;
  logic          w_ifid_flush;
  logic          w_idex_flush;
  logic          w_exmem_flush;
  logic          w_pc_redirect;
  logic [AW-1:0] w_redirect_pc;

  assign w_lu = i_hz.ex_memread && (i_hz.ex_rd != 5'd0) &&
                ((i_hz.id_uses_rs && (i_hz.ex_rd == i_hz.id_rs)) ||
                 (i_hz.id_uses_rt && (i_hz.ex_rd == i_hz.id_rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_pend_pc <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pend_pc <= w_pend_pc_next;
    end
  end

  // Fixed priority: D-cache freeze, redirect in RUN, pending redirect, load-use, I-cache stall.
  always_comb begin
    w_state_next   = r_state;
    w_pend_pc_next = r_pend_pc;
    w_pc_en        = 1'b1;
    w_ifid_en      = 1'b1;
    w_idex_en      = 1'b1;
    w_exmem_en     = 1'b1;
    w_memwb_en     = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_flush   = 1'b0;
    w_exmem_flush  = 1'b0;
    w_pc_redirect  = 1'b0;
    w_redirect_pc  = (r_state == PEND) ? r_pend_pc : i_hz.mem_target;

    if (rst) begin
      w_pc_en    = 1'b0;
      w_ifid_en  = 1'b0;
      w_idex_en  = 1'b0;
      w_exmem_en = 1'b0;
      w_memwb_en = 1'b0;
    end else if (i_hz.dcache_stall) begin
      w_pc_en    = 1'b0;
      w_ifid_en  = 1'b0;
      w_idex_en  = 1'b0;
      w_exmem_en = 1'b0;
      w_memwb_en = 1'b0;
    end else if ((r_state == RUN) && i_hz.mem_taken) begin
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
      if (!i_hz.icache_stall) begin
        w_pc_redirect = 1'b1;
      end else begin
        w_pc_en        = 1'b0;
        w_pend_pc_next = i_hz.mem_target;
        w_state_next   = PEND;
      end
    end else if (r_state == PEND) begin
      // The fetch slot behind a pending redirect is wrong-path, so it is always bubbled.
      w_ifid_flush = 1'b1;
      if (i_hz.icache_stall) begin
        w_pc_en = 1'b0;
      end else begin
        w_pc_redirect = 1'b1;
        w_state_next  = RUN;
      end
    end else if (w_lu) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
    end else if (i_hz.icache_stall) begin
      w_pc_en      = 1'b0;
      w_ifid_flush = 1'b1;
    end
  end

  assign i_hz.pc_en       = w_pc_en;
  assign i_hz.ifid_en     = w_ifid_en;
  assign i_hz.idex_en     = w_idex_en;
  assign i_hz.exmem_en    = w_exmem_en;
  assign i_hz.memwb_en    = w_memwb_en;
  assign i_hz.ifid_flush  = w_ifid_flush;
  assign i_hz.idex_flush  = w_idex_flush;
  assign i_hz.exmem_flush = w_exmem_flush;
  assign i_hz.pc_redirect = w_pc_redirect;
  assign i_hz.redirect_pc = w_redirect_pc;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (!w_pc_en)
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_ifid_flush || w_idex_flush || w_exmem_flush)
        r_flush_events <= r_flush_events + 32'd1;
    end
  end

  assign i_hz.stall_cycles = r_stall_cycles;
  assign i_hz.flush_events = r_flush_events;
`else
  assign i_hz.stall_cycles = 32'd0;
  assign i_hz.flush_events = 32'd0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. It drives the write-enable and flush (bubble-insert) controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Inputs are the load-use hazard operands, the branch/jump resolution made in MEM, and the I-cache and D-cache stall lines. It holds a taken redirect that cannot be applied while the I-cache is busy, and applies it when the I-cache releases.

## Interface
Parameters:
- `AW`, default 32: PC / redirect address width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `id_rs`, `id_rt`, in, 5 each: source register numbers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`, in, 1 each: the ID instruction actually reads that source.
- `ex_memread`, in, 1: the instruction in EX is a load.
- `ex_rd`, in, 5: destination register of the instruction in EX.
- `mem_taken`, in, 1: branch taken or jump/JAL, resolved in MEM.
- `mem_target`, in, AW: redirect address from MEM.
- `icache_stall`, in, 1: the I-cache cannot deliver an instruction this cycle.
- `dcache_stall`, in, 1: the D-cache cannot complete the MEM access this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`, out, 1 each: register load enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, out, 1 each: load a NOP/zero-control bubble on the next edge. Each is only asserted together with the matching `_en`.
- `pc_redirect`, out, 1: PC loads `redirect_pc` instead of PC+4.
- `redirect_pc`, out, AW: the redirect address.
- `stall_cycles`, out, 32: performance counter, see Configuration.
- `flush_events`, out, 32: performance counter, see Configuration.

## Operation
- The FSM has two states: RUN and PEND. Registers: `state`, `pend_pc[AW-1:0]`, and the counters.
- Load-use hazard `lu` is asserted when all of the following hold:
  - `ex_memread` = 1;
  - `ex_rd` ≠ 0;
  - either (`id_uses_rs` and `ex_rd` == `id_rs`) or (`id_uses_rt` and `ex_rd` == `id_rt`).
- Output decode uses fixed priority, evaluated every cycle. Any signal not named in a case is: enables = 1, flushes = 0, `pc_redirect` = 0.
  1. `dcache_stall`: all five enables = 0. No flushes, no state change, and any pending redirect is held.
  2. RUN with `mem_taken`: flush IF/ID, ID/EX and EX/MEM.
     - If `icache_stall` = 0: `pc_redirect` = 1 and `redirect_pc` = `mem_target`.
     - Else: `pc_en` = 0, `pend_pc` <= `mem_target`, state -> PEND.
  3. PEND:
     - If `icache_stall` = 1: `pc_en` = 0 and `ifid_flush` = 1.
     - Else: `pc_redirect` = 1, `redirect_pc` = `pend_pc`, `ifid_flush` = 1 (this discards the wrong-path fetch), state -> RUN.
     - `mem_taken` is ignored in PEND, because a younger redirect cannot be in MEM.
  4. RUN with `lu`: `pc_en` = 0, `ifid_en` = 0, `idex_flush` = 1. This applies regardless of `icache_stall`.
  5. RUN with `icache_stall`: `pc_en` = 0 and `ifid_flush` = 1; the downstream stages advance.
- `redirect_pc` = `mem_target` in RUN and `pend_pc` in PEND.
- While `rst` = 1: all enables = 0, all flushes = 0, `pc_redirect` = 0.

## Timing
- All control outputs are combinational from the current inputs and state. They take effect at the next rising `clk`.
- Load-use costs exactly 1 bubble. In the following cycle `lu` is 0 because the load has moved to MEM.
- A taken branch with the I-cache idle costs a 3-instruction flush, and the correct-path fetch begins 1 cycle later.
- A taken branch under `icache_stall`: the redirect is applied on the first cycle in PEND with `icache_stall` = 0 and `dcache_stall` = 0.
- `dcache_stall` concurrent with `mem_taken` in RUN: the whole pipeline is frozen and the branch stays in MEM. It is serviced when `dcache_stall` drops.
- Reset values: `state` = RUN, `pend_pc` = 0, `stall_cycles` = 0, `flush_events` = 0.
- Asserting `rst` while in PEND discards the pending redirect.

## Configuration
- The macro is `PIPE_HAZARD_PERF_EN`.
- When defined:
  - `stall_cycles` increments on every non-reset cycle with `pc_en` = 0.
  - `flush_events` increments on every cycle in which at least one flush output = 1.
  - Both counters wrap from 0xFFFFFFFF to 0.
- When undefined: both outputs are constant 0 and no counter flops are built.

## Test plan
- Load-use: `ex_memread` = 1, `ex_rd` = 8, `id_rs` = 8, `id_uses_rs` = 1, no stalls.
  - Required: `pc_en` = 0, `ifid_en` = 0, `idex_flush` = 1 for 1 cycle.
  - Repeat with `ex_rd` = 0: no stall.
- Branch with the I-cache idle: `mem_taken` = 1, `mem_target` = 0x0000_0040.
  - Required: `pc_redirect` = 1, `redirect_pc` = 0x40, and IF/ID, ID/EX, EX/MEM flushes = 1 in the same cycle; state stays RUN.
- Branch under I-cache stall: `mem_taken` = 1 with `icache_stall` = 1, then `icache_stall` = 1 for 3 more cycles, then 0.
  - Required: state = PEND for 4 cycles, `pc_en` = 0.
  - Then `pc_redirect` = 1 with `redirect_pc` = the latched target and `ifid_flush` = 1, then RUN.
- D-cache stall over a taken branch: `dcache_stall` = 1 for 5 cycles with `mem_taken` = 1.
  - Required: all enables = 0 and no flushes for 5 cycles; the redirect happens in the 6th cycle.
- Reset in PEND: assert `rst` while in PEND, then release.
  - Required: state = RUN, no redirect, counters = 0.
- Counters (`PIPE_HAZARD_PERF_EN` defined): 1 load-use, 1 branch, and 5 D-cache stall cycles.
  - Required: `stall_cycles` = 6, `flush_events` = 2.
  - Required with the macro undefined: both outputs = 0.
